// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/ADDR/LEN/DATA[/CSUM] frames, writes program memory,
// and holds the core until a complete image is loaded. Optional checksum: PROG_LOADER_CSUM_EN.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 9;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            we_nxt;
    logic [DW-1:0]   addr_nxt, wdata_nxt;
    logic            hold_nxt, done_nxt, err_nxt;
    logic            accept_c;
`ifdef PROG_LOADER_CSUM_EN
    logic [DW-1:0]   sum, sum_nxt;
`endif

    assign accept_c = s_valid && s_ready;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_SYNC;
            ptr       <= '0;
            cnt       <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            sum       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            s_ready   <= 1'b1;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            cpu_hold  <= hold_nxt;
            busy      <= (state_nxt != ST_SYNC);
            done      <= done_nxt;
            err       <= err_nxt;
`ifdef PROG_LOADER_CSUM_EN
            sum       <= sum_nxt;
`endif
        end
    end

    // Frame parser: next state and next output values
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        we_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        hold_nxt  = cpu_hold;
        done_nxt  = 1'b0;
        err_nxt   = err;
`ifdef PROG_LOADER_CSUM_EN
        sum_nxt   = sum;
`endif
        if (accept_c) begin
            case (state)
                ST_SYNC: begin
                    if (s_data == SYNC_BYTE) begin
                        hold_nxt  = 1'b1;
                        err_nxt   = 1'b0;
                        state_nxt = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    ptr_nxt   = s_data;
`ifdef PROG_LOADER_CSUM_EN
                    sum_nxt   = s_data;
`endif
                    state_nxt = ST_LEN;
                end
                ST_LEN: begin
                    // A zero length byte encodes a full 256-byte image
                    cnt_nxt   = (s_data == 8'h00) ? 9'd256 : CW'({1'b0, s_data});
`ifdef PROG_LOADER_CSUM_EN
                    sum_nxt   = DW'(sum + s_data);
`endif
                    state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ptr;
                    wdata_nxt = s_data;
                    ptr_nxt   = DW'(ptr + 8'd1);
                    cnt_nxt   = CW'(cnt - 9'd1);
`ifdef PROG_LOADER_CSUM_EN
                    sum_nxt   = DW'(sum + s_data);
                    if (cnt == 9'd1) begin
                        state_nxt = ST_CSUM;
                    end
`else
                    if (cnt == 9'd1) begin
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                        state_nxt = ST_SYNC;
                    end
`endif
                end
`ifdef PROG_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (DW'(sum + s_data) == 8'h00) begin
                        done_nxt = 1'b1;
                        hold_nxt = 1'b0;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                    state_nxt = ST_SYNC;
                end
`endif
                default: state_nxt = ST_SYNC;
            endcase
        end
    end

endmodule
